uart_tx: RTL

//  UART transmitter: serialises one DATA_WIDTH-bit word per frame (start, data LSB-first, optional parity, stop).
//  Bit period is Prescale clock cycles, with timing generated internally from CLK.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Bit period is a captured, clamped Prescale count of CLK cycles.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int          IW   = $clog2(DATA_WIDTH);
    localparam logic [3:0]  LAST = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [5:0]            presc_q, presc_d;

    logic                  bit_end;
    logic                  par_bit;
    logic [5:0]            presc_clamped;
    logic [3:0]            nxt_idx;

    assign presc_clamped = (Prescale < 6'd4) ? 6'd4 : Prescale;
    assign bit_end       = (edge_cnt_q == (presc_q - 6'd1));
    assign par_bit       = (^data_q) ^ par_typ_q;
    assign nxt_idx       = bit_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        edge_cnt_d = 6'd0;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        presc_d    = presc_q;

        // Edge counter free-runs within a bit and wraps on each boundary.
        if (state_q != IDLE && !bit_end) begin
            edge_cnt_d = edge_cnt_q + 6'd1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    edge_cnt_d = 6'd0;
                    bit_cnt_d  = 4'd0;
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    presc_d    = presc_clamped;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = nxt_idx;
                        tx_d      = data_q[nxt_idx[IW-1:0]];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= 4'd0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= 6'd0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            presc_q    <= presc_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule
